// File: rtl/side_road_request_unit_pkg.sv
// -----------------------------------------------------------------------------
// side_road_request_unit_pkg
// Shared definitions for the side-road request unit:
//   - state_t    : request FSM state encoding (IDLE=0, REQ=1, GRANTED=2, HOLDOFF=3)
//   - SRC_CAR/SRC_PED : bit positions of the car and pedestrian sources in
//                  req_src and in the pending latch
//   - default debounce length, holdoff length and counter width
// -----------------------------------------------------------------------------
package side_road_request_unit_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      GRANTED = 2'd2,
      HOLDOFF = 2'd3
   } state_t;

   localparam int SRC_CAR = 0;
   localparam int SRC_PED = 1;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_HOLDOFF_TICKS   = 3;
   localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/side_road_request_unit_input_debouncer.sv
// -----------------------------------------------------------------------------
// side_road_request_unit_input_debouncer
// Two-flop synchroniser, debounce counter and registered rise pulse for one
// asynchronous input. The debounced level flips only after the synchronised
// value has differed from it for DEBOUNCE_CYCLES consecutive clk cycles.
// Ports:
//   clk   in  system clock
//   reset in  synchronous reset, active-low
//   raw   in  asynchronous input
//   rise  out one-cycle pulse on a debounced 0->1 transition
// -----------------------------------------------------------------------------
module side_road_request_unit_input_debouncer
   import side_road_request_unit_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic rise
);

   // Counter value on the cycle where the next mismatch completes the window
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_r;
   logic             sync2_r;
   logic             level_r;
   logic             rise_r;
   logic [CNT_W-1:0] cnt_r;

   // Synchronise, debounce and generate the registered rise pulse
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         level_r <= 1'b0;
         rise_r  <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         sync1_r <= raw;
         sync2_r <= sync1_r;
         rise_r  <= 1'b0;
         if (sync2_r != level_r) begin
            if (cnt_r == LAST_CNT) begin
               level_r <= sync2_r;
               cnt_r   <= {CNT_W{1'b0}};
               // only the 0->1 flip is an event
               rise_r  <= sync2_r;
            end else begin
               cnt_r <= cnt_r + CNT_W'(1);
            end
         end else begin
            cnt_r <= {CNT_W{1'b0}};
         end
      end
   end

   assign rise = rise_r;

endmodule

// File: rtl/side_road_request_unit.sv
// -----------------------------------------------------------------------------
// side_road_request_unit
// Conditions the raw side-road car sensor and pedestrian button into a clean
// service request for the traffic light controller, holds it until the
// controller grants side-road green, and enforces a holdoff (in clk_1s ticks)
// before the next request so the main road is not starved.
// Ports:
//   clk            in  system clock
//   reset          in  synchronous reset, active-low
//   clk_1s         in  1 s clock from the controller (edge detected in clk domain)
//   car_sense_raw  in  asynchronous car sensor
//   ped_button_raw in  asynchronous pedestrian button
//   ack            in  controller grant, high while side road is green
//   req            out side-road service request
//   req_src        out request sources (bit0 car, bit1 pedestrian), 0 when req=0
//   pending        out an event is latched but not yet requested
//   state_o        out current FSM state (debug)
// Build option:
//   PED_PRIORITY_EN - when defined, a pending pedestrian event ends HOLDOFF
//                     immediately; otherwise the holdoff always completes.
// -----------------------------------------------------------------------------
module side_road_request_unit
   import side_road_request_unit_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLDOFF_TICKS   = DEF_HOLDOFF_TICKS,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk_1s,
   input  logic       car_sense_raw,
   input  logic       ped_button_raw,
   input  logic       ack,
   output logic       req,
   output logic [1:0] req_src,
   output logic       pending,
   output logic [1:0] state_o
);

   logic [1:0]       ev_s;
   logic             tick_s;
   logic             ped_force_s;
   logic [1:0]       pend_in_s;

   state_t           state_r;
   state_t           state_s;
   logic [1:0]       src_r;
   logic [1:0]       src_s;
   logic [1:0]       pend_r;
   logic [1:0]       pend_s;
   logic [CNT_W-1:0] hold_r;
   logic [CNT_W-1:0] hold_s;
   logic             req_r;
   logic             pending_r;

   side_road_request_unit_input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_car_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (car_sense_raw),
      .rise (ev_s[SRC_CAR])
   );

   side_road_request_unit_input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_ped_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (ped_button_raw),
      .rise (ev_s[SRC_PED])
   );

   // clk_1s is already clean; a one-cycle window just gives sync + edge detect
   side_road_request_unit_input_debouncer #(
      .DEBOUNCE_CYCLES(1),
      .CNT_W          (CNT_W)
   ) u_tick_det (
      .clk  (clk),
      .reset(reset),
      .raw  (clk_1s),
      .rise (tick_s)
   );

`ifdef PED_PRIORITY_EN
   assign ped_force_s = pend_r[SRC_PED];
`else
   assign ped_force_s = 1'b0;
`endif

   // events arriving this cycle are latched before any HOLDOFF exit decision
   assign pend_in_s = pend_r | ev_s;

   // Next-state, source, pending and holdoff counter logic
   always_comb begin
      state_s = state_r;
      src_s   = src_r;
      pend_s  = pend_r;
      hold_s  = hold_r;
      case (state_r)
         IDLE: begin
            if (ev_s != 2'b00) begin
               state_s = REQ;
               src_s   = ev_s;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (ack) begin
               // an event on the grant edge waits for the next request
               state_s = GRANTED;
               src_s   = 2'b00;
               pend_s  = pend_in_s;
            end else begin
               src_s = src_r | ev_s;
            end
         end
         GRANTED: begin
            pend_s = pend_in_s;
            if (!ack) begin
               state_s = HOLDOFF;
               hold_s  = CNT_W'(HOLDOFF_TICKS);
            end else begin
               state_s = GRANTED;
            end
         end
         HOLDOFF: begin
            pend_s = pend_in_s;
            if (ped_force_s || (tick_s && (hold_r == CNT_W'(1)))) begin
               hold_s = {CNT_W{1'b0}};
               if (pend_in_s != 2'b00) begin
                  state_s = REQ;
                  src_s   = pend_in_s;
                  pend_s  = 2'b00;
               end else begin
                  state_s = IDLE;
               end
            end else if (tick_s) begin
               hold_s = hold_r - CNT_W'(1);
            end else begin
               hold_s = hold_r;
            end
         end
         default: begin
            state_s = IDLE;
            src_s   = 2'b00;
            pend_s  = 2'b00;
            hold_s  = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= IDLE;
         src_r     <= 2'b00;
         pend_r    <= 2'b00;
         hold_r    <= {CNT_W{1'b0}};
         req_r     <= 1'b0;
         pending_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         src_r     <= src_s;
         pend_r    <= pend_s;
         hold_r    <= hold_s;
         req_r     <= (state_s == REQ);
         pending_r <= |pend_s;
      end
   end

   // src_r is cleared whenever REQ is left, so it is already 0 while req=0
   assign req     = req_r;
   assign req_src = src_r;
   assign pending = pending_r;
   assign state_o = state_r;

endmodule
